// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and IR, reads instruction memory with a
// ready-based handshake and hands opcode/mm to the controller.
module fetch_unit #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_f,
  input  logic        fetch_req,
  input  logic        pc_write,
  input  logic        br_sel,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic [31:0] imem_data,
  input  logic        imem_rdy,
  output logic [31:0] ir,
  output logic [3:0]  opcode,
  output logic [3:0]  mm,
  output logic [15:0] pc,
  output logic        busy,
  output logic        fetch_done,
  output logic        fetch_err,
  output logic        dbg_state
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Last wait count before the abort edge: the TIMEOUT-th BUSY edge sees cnt_q == TIMEOUT-1.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        rd_q, rd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [15:0] pc_inc;
  logic [15:0] br_target;

  assign pc_inc    = pc_q + 16'd1;
  assign br_target = br_sel ? (pc_q + ir_q[15:0]) : ir_q[15:0];

  // Handshake: imem_rd stays high for the whole BUSY period; the word is
  // taken at the first edge where imem_rdy is high, and imem_rdy is a don't-care
  // whenever imem_rd is low.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    rd_d    = rd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pc_write) begin
          pc_d = br_target;
        end
        if (fetch_req) begin
          state_d = BUSY;
          rd_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = 8'd0;
        end
      end
      BUSY: begin
        if (imem_rdy) begin
          state_d = IDLE;
          ir_d    = imem_data;
          pc_d    = pc_inc;
          rd_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (cnt_q == LAST_WAIT) begin
          // Abort: substitute a NOOP and move on so the controller never stalls.
          state_d = IDLE;
          ir_d    = 32'h0;
          pc_d    = pc_inc;
          rd_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= IDLE;
      pc_q    <= 16'h0;
      ir_q    <= 32'h0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr  = pc_q;
  assign imem_rd    = rd_q;
  assign ir         = ir_q;
  assign opcode     = ir_q[31:28];
  assign mm         = ir_q[27:24];
  assign pc         = pc_q;
  assign busy       = busy_q;
  assign fetch_done = done_q;
  assign fetch_err  = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed fetches and branches; a monitor checks each
// fetch_done against a queue of expected {ir, pc, fetch_err}.
module tb_fetch_unit;

  localparam int TIMEOUT = 8;
  localparam int W = 49;

  logic        clk;
  logic        rst_f;
  logic        fetch_req;
  logic        pc_write;
  logic        br_sel;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [31:0] imem_data;
  logic        imem_rdy;
  logic [31:0] ir;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] pc;
  logic        busy;
  logic        fetch_done;
  logic        fetch_err;
  logic        dbg_state;

  fetch_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .fetch_req  (fetch_req),
    .pc_write   (pc_write),
    .br_sel     (br_sel),
    .imem_addr  (imem_addr),
    .imem_rd    (imem_rd),
    .imem_data  (imem_data),
    .imem_rdy   (imem_rdy),
    .ir         (ir),
    .opcode     (opcode),
    .mm         (mm),
    .pc         (pc),
    .busy       (busy),
    .fetch_done (fetch_done),
    .fetch_err  (fetch_err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int n_total = 0;
  int n_bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0] m_pc;
  logic [31:0] m_ir;
  logic        m_err;
  logic        prev_done = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_f === 1'b1 && fetch_done === 1'b1) begin
      chk("done_one_cycle", prev_done, 1'b0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_ir", ir, e[48:17]);
        chk("sb_opcode", opcode, e[48:45]);
        chk("sb_mm", mm, e[44:41]);
        chk("sb_pc", pc, e[16:1]);
        chk("sb_err", fetch_err, e[0]);
      end
    end
    prev_done = (rst_f === 1'b1) ? fetch_done : 1'b0;
  end

  // driver tasks
  task automatic do_fetch(input logic [31:0] data, input int waits, input bit br_with_req,
                          input bit br_rel, input bit pulse_in_busy);
    bit tmo;
    int nw;
    logic [15:0] pc_at;
    tmo = (waits >= TIMEOUT);
    nw  = tmo ? TIMEOUT - 1 : waits;
    fetch_req = 1'b1;
    pc_write  = br_with_req;
    br_sel    = br_rel;
    imem_data = data;
    imem_rdy  = (waits == 0);
    if (br_with_req) m_pc = br_rel ? m_pc + m_ir[15:0] : m_ir[15:0];
    pc_at = m_pc;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    pc_write  = 1'b0;
    chk("busy_start", busy, 1'b1);
    chk("rd_start", imem_rd, 1'b1);
    chk("addr_start", imem_addr, pc_at);
    m_ir = tmo ? 32'h0 : data;
    m_pc = pc_at + 16'd1;
    if (tmo) m_err = 1'b1;
    exp_q.push_back({m_ir, m_pc, m_err});
    for (int k = 0; k < nw; k++) begin
      if (pulse_in_busy && k == 0) begin
        fetch_req = 1'b1;
        pc_write  = 1'b1;
        br_sel    = 1'b0;
      end
      @(posedge clk); #1;
      fetch_req = 1'b0;
      pc_write  = 1'b0;
      chk("busy_wait", busy, 1'b1);
      chk("no_done_wait", fetch_done, 1'b0);
      chk("pc_hold_wait", pc, pc_at);
    end
    imem_rdy = !tmo;
    @(posedge clk); #1;
    imem_rdy = 1'b0;
    chk("done_latency", fetch_done, 1'b1);
    chk("busy_end", busy, 1'b0);
    chk("rd_end", imem_rd, 1'b0);
  endtask

  task automatic do_branch(input bit rel);
    pc_write = 1'b1;
    br_sel   = rel;
    m_pc = rel ? m_pc + m_ir[15:0] : m_ir[15:0];
    @(posedge clk); #1;
    pc_write = 1'b0;
    chk(rel ? "branch_rel" : "branch_abs", pc, m_pc);
    chk("branch_no_busy", busy, 1'b0);
  endtask

  task automatic chk_reset_values(input string nm);
    chk({nm, "_pc"}, pc, 16'h0);
    chk({nm, "_ir"}, ir, 32'h0);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_rd"}, imem_rd, 1'b0);
    chk({nm, "_done"}, fetch_done, 1'b0);
    chk({nm, "_err"}, fetch_err, 1'b0);
  endtask

  initial begin
    rst_f = 1'b1; fetch_req = 1'b0; pc_write = 1'b0; br_sel = 1'b0;
    imem_data = 32'h0; imem_rdy = 1'b0;
    m_pc = 16'h0; m_ir = 32'h0; m_err = 1'b0;

    // mid-cycle reset, then idle
    #7 rst_f = 1'b0;
    #1 chk_reset_values("reset");
    @(negedge clk); rst_f = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_reset_values("idle3");

    // zero-wait fetch
    do_fetch(32'h8123_4005, 0, 0, 0, 0);
    // wait states, with ignored fetch_req/pc_write during BUSY
    do_fetch(32'h1234_5678, 3, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1 chk("no_second_fetch", busy, 1'b0);
    // longest legal wait: data arrives on the timeout edge
    do_fetch(32'hDEAD_BEEF, TIMEOUT - 1, 0, 0, 0);
    // timeout, then a normal fetch with the sticky error
    do_fetch(32'hFFFF_FFFF, TIMEOUT, 0, 0, 0);
    do_fetch(32'h5A5A_0001, 1, 0, 0, 0);

    // branches and PC wrap
    do_fetch(32'h1000_0040, 0, 0, 0, 0);
    do_branch(0);
    do_fetch(32'h2000_FFFF, 0, 0, 0, 0);
    do_branch(0);
    do_fetch(32'h3000_FFEF, 0, 0, 0, 0);
    do_branch(0);
    do_fetch(32'h4000_0020, 2, 0, 0, 0);
    chk("pc_fff0", pc, 16'hFFF0);
    do_branch(1);
    chk("rel_wrap", pc, 16'h0010);
    do_fetch(32'h6000_0100, 1, 1, 0, 0);
    do_fetch(32'h7000_0000, 0, 1, 1, 0);

    // reset during BUSY
    fetch_req = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_f = 1'b0;
    #1 chk_reset_values("rst_busy");
    @(negedge clk); rst_f = 1'b1;
    m_pc = 16'h0; m_ir = 32'h0; m_err = 1'b0;
    imem_data = 32'hCAFE_F00D;
    imem_rdy  = 1'b1;
    repeat (3) @(posedge clk);
    #1 imem_rdy = 1'b0;
    chk_reset_values("after_rst_busy");
    repeat (2) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
